// File: rtl/hub75_scan.sv
// Framebuffer reader driving a 64x64 1/32-scan HUB75 panel, one row pair per pass.
// Latency: pixel pair reaches R/G/B one cycle after its bottom read; row pair = 4*COLS+2+DISPLAY_CYCLES cycles.
// Backpressure: none; free-running scan, read port is assumed to always answer one cycle later.
module hub75_scan #(
    parameter int COLS           = 64,
    parameter int ROWS           = 64,
    parameter int DISPLAY_CYCLES = 256
) (
    input  logic        clk_in,
    input  logic        reset,
    output logic        rd_en,
    output logic [11:0] rd_addr,
    input  logic [2:0]  rd_data,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    output logic        E,
    output logic        R1,
    output logic        G1,
    output logic        B1,
    output logic        R2,
    output logic        G2,
    output logic        B2,
    output logic        CLK,
    output logic        LAT,
    output logic        OE,
    output logic        frame_done
);

    localparam int              HALF      = ROWS / 2;
    localparam int              CW        = $clog2(DISPLAY_CYCLES + 1);
    localparam logic [4:0]      LAST_ROW  = 5'(HALF - 1);
    localparam logic [5:0]      LAST_COL  = 6'(COLS - 1);
    localparam logic [5:0]      HALF_Y    = 6'(HALF);
    localparam logic [CW-1:0]   DISP_LOAD = CW'(DISPLAY_CYCLES);

    typedef enum logic [2:0] {
        RD_TOP,
        RD_BOT,
        CLK_LO,
        CLK_HI,
        BLANK,
        LATCH,
        DISPLAY
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            run;
    logic [4:0]      row;
    logic [4:0]      row_addr;
    logic [5:0]      col;
    logic [CW-1:0]   disp_cnt;
    logic [2:0]      hold;
    logic [5:0]      rgb_q;
    logic [5:0]      rgb;
    logic            disp_last;

    assign disp_last = (state == DISPLAY) && (disp_cnt == CW'(1));

    // run gates the very first read so rd_en stays low while reset is held
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state <= RD_TOP;
            run   <= 1'b0;
        end else begin
            state <= state_next;
            run   <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        rd_en      = 1'b0;
        rd_addr    = {1'b0, row, col};
        CLK        = 1'b0;
        LAT        = 1'b0;
        OE         = 1'b1;
        frame_done = 1'b0;
        rgb        = rgb_q;
        case (state)
            RD_TOP: begin
                rd_en = run;
                if (run) state_next = RD_BOT;
            end
            RD_BOT: begin
                rd_en      = 1'b1;
                rd_addr    = {{1'b0, row} + HALF_Y, col};
                state_next = CLK_LO;
            end
            CLK_LO: begin
                // bottom pixel only exists on rd_data this cycle, so present it directly
                rgb        = {hold, rd_data};
                state_next = CLK_HI;
            end
            CLK_HI: begin
                CLK        = 1'b1;
                state_next = (col == LAST_COL) ? BLANK : RD_TOP;
            end
            BLANK: state_next = LATCH;
            LATCH: begin
                LAT        = 1'b1;
                state_next = DISPLAY;
            end
            DISPLAY: begin
                OE = 1'b0;
                if (disp_last) begin
                    state_next = RD_TOP;
                    frame_done = (row == LAST_ROW);
                end
            end
            default: state_next = RD_TOP;
        endcase
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            row      <= '0;
            col      <= '0;
            row_addr <= '0;
            disp_cnt <= '0;
            hold     <= '0;
            rgb_q    <= '0;
        end else begin
            case (state)
                RD_BOT: hold  <= rd_data;
                CLK_LO: rgb_q <= {hold, rd_data};
                CLK_HI: if (col != LAST_COL) col <= col + 6'd1;
                LATCH: begin
                    row_addr <= row;
                    disp_cnt <= DISP_LOAD;
                end
                DISPLAY: begin
                    if (disp_last) begin
                        col <= '0;
                        row <= (row == LAST_ROW) ? 5'd0 : row + 5'd1;
                    end else begin
                        disp_cnt <= disp_cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign {R1, G1, B1, R2, G2, B2} = rgb;
    assign {E, D, C, B, A}          = row_addr;

endmodule

// File: tb/tb_hub75_scan.sv
// Bench for hub75_scan: framebuffer model on the read port, cycle-indexed output model.
// Latency: model time zero is the first cycle rd_en is seen after reset release.
// Backpressure: none; the read port answers every read one cycle later.
module tb_hub75_scan;

    localparam int COLS = 64;
    localparam int ROWS = 64;
    localparam int DC   = 4;
    localparam int HALF = ROWS / 2;
    localparam int P    = 4 * COLS + 2 + DC;
    localparam int FRAME = HALF * P;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        rd_en;
    logic [11:0] rd_addr;
    logic [2:0]  rd_data;
    logic        A, B, C, D, E;
    logic        R1, G1, B1, R2, G2, B2;
    logic        CLK, LAT, OE, frame_done;

    logic [2:0]  fb [4096];
    int          n_chk  = 0;
    int          n_fail = 0;
    int          t      = 0;
    int          last_t = -1;
    int          oe_run = 0;
    bit          armed    = 1'b0;
    bit          model_on = 1'b0;
    logic [5:0]  prev_rgb;
    logic        pend_en;
    logic [11:0] pend_addr;

    hub75_scan #(.COLS(COLS), .ROWS(ROWS), .DISPLAY_CYCLES(DC)) dut (
        .clk_in(clk_in), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .A(A), .B(B), .C(C), .D(D), .E(E),
        .R1(R1), .G1(G1), .B1(B1), .R2(R2), .G2(G2), .B2(B2),
        .CLK(CLK), .LAT(LAT), .OE(OE), .frame_done(frame_done)
    );

    always #5 clk_in = ~clk_in;

    // synchronous read port: data valid for the cycle after a read, garbage otherwise
    initial begin
        rd_data = 3'b000;
        forever begin
            @(negedge clk_in);
            pend_en   = rd_en;
            pend_addr = rd_addr;
            @(posedge clk_in);
            #1;
            rd_data = pend_en ? fb[pend_addr] : 3'($urandom);
        end
    end

    function automatic logic [5:0] rgb_now();
        return {R1, G1, B1, R2, G2, B2};
    endfunction

    function automatic logic [27:0] out_vec();
        return {rd_en, (rd_en ? rd_addr : 12'h000), E, D, C, B, A,
                R1, G1, B1, R2, G2, B2, CLK, LAT, OE, frame_done};
    endfunction

    function automatic logic [5:0] pair(int r, int c);
        return {fb[r * 64 + c], fb[(r + HALF) * 64 + c]};
    endfunction

    // What the panel side must show at model cycle tt, from the scan timing rules alone
    function automatic logic [27:0] model_exp(int tt);
        int rp, r, p, col, ph, pr;
        logic        en;
        logic [11:0] addr;
        logic [4:0]  ra;
        logic [5:0]  c;
        rp   = tt / P;
        r    = rp % HALF;
        p    = tt % P;
        col  = p / 4;
        ph   = p % 4;
        pr   = (r + HALF - 1) % HALF;
        en   = (p < 4 * COLS) && (ph < 2);
        addr = 12'h000;
        if (en) addr = (ph == 0) ? 12'(r * 64 + col) : 12'((r + HALF) * 64 + col);
        ra = (p >= 4 * COLS + 2) ? 5'(r) : ((rp == 0) ? 5'd0 : 5'(pr));
        if (p >= 4 * COLS)  c = pair(r, COLS - 1);
        else if (ph >= 2)   c = pair(r, col);
        else if (col > 0)   c = pair(r, col - 1);
        else if (rp == 0)   c = 6'd0;
        else                c = pair(pr, COLS - 1);
        return {en, addr, ra, c, (p < 4 * COLS) && (ph == 3), p == 4 * COLS + 1,
                !(p >= 4 * COLS + 2), (p == P - 1) && (r == HALF - 1)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at model cycle %0d: got %0h, want %0h", name, last_t, act, exp);
        end
    endtask

    always @(negedge clk_in) begin
        if (armed && !model_on && rd_en) begin
            model_on = 1'b1;
            t        = 0;
            oe_run   = 0;
            prev_rgb = rgb_now();
        end
        if (model_on) begin
            last_t = t;
            chk("model", 32'(out_vec()), 32'(model_exp(t)));
            if (!OE) begin
                chk("oe_exclusive", {30'd0, LAT, CLK}, 32'd0);
                oe_run++;
            end else if (oe_run != 0) begin
                chk("oe_low_len", oe_run, DC);
                oe_run = 0;
            end
            if (CLK) chk("rgb_hold_clk_hi", 32'(rgb_now()), 32'(prev_rgb));
            prev_rgb = rgb_now();
            t++;
        end
    end

    task automatic step();
        @(negedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        armed    = 1'b0;
        model_on = 1'b0;
        reset    = 1'b1;
    endtask

    task automatic start_scan();
        @(negedge clk_in);
        reset = 1'b0;
        armed = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (model_on) break;
        end
        if (!model_on) begin
            $display("FAIL sync: no rd_en within 6 cycles of reset release");
            $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
            $fatal(1);
        end
    endtask

    task automatic fill_halves();
        for (int a = 0; a < 4096; a++) fb[a] = (a % 64 < 32) ? 3'b100 : 3'b001;
    endtask

    initial begin
        int   rises, fd_n, fd_t1, fd_t2;
        logic prev_clk, fd_prev;

        // reset state and first reads on an empty framebuffer
        reset = 1'b1;
        for (int a = 0; a < 4096; a++) fb[a] = 3'b000;
        repeat (2) @(negedge clk_in);
        chk("reset_oe", 32'(OE), 32'd1);
        chk("reset_lat", 32'(LAT), 32'd0);
        chk("reset_clk", 32'(CLK), 32'd0);
        chk("reset_rd_en", 32'(rd_en), 32'd0);
        start_scan();
        chk("first_addr", {19'd0, rd_en, rd_addr}, 32'h1000);
        step();
        chk("second_addr", {19'd0, rd_en, rd_addr}, 32'h1800);
        for (int i = 0; i < 400; i++) begin
            if (LAT) break;
            step();
        end
        chk("first_lat_cycle", last_t, 257);

        // left half red, right half blue; two full frames
        do_reset();
        fill_halves();
        repeat (2) @(negedge clk_in);
        start_scan();
        rises    = 0;
        prev_clk = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (LAT) break;
            if (CLK && !prev_clk) begin
                rises++;
                if (rises <= 32) chk("left_red", 32'(rgb_now()), 32'b100100);
                else             chk("right_blue", 32'(rgb_now()), 32'b001001);
            end
            prev_clk = CLK;
            step();
        end
        chk("rises_before_lat", rises, 64);
        fd_n    = 0;
        fd_t1   = -1;
        fd_t2   = -1;
        fd_prev = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step();
            if (last_t >= 5 * P + 4 * COLS + 2 && last_t < 6 * P)
                chk("row5_addr", {27'd0, E, D, C, B, A}, 32'b00101);
            if (fd_prev) chk("wrap_addr", {19'd0, rd_en, rd_addr}, 32'h1000);
            if (frame_done) begin
                fd_n++;
                if (fd_n == 1) fd_t1 = last_t;
                else           fd_t2 = last_t;
            end
            fd_prev = frame_done;
        end
        chk("frame_done_count", fd_n, 2);
        chk("frame_done_first", fd_t1, FRAME - 1);
        chk("frame_done_period", fd_t2 - fd_t1, FRAME);

        // reset asserted mid-column 40 of row 7
        do_reset();
        repeat (2) @(negedge clk_in);
        start_scan();
        for (int i = 0; i < 3000; i++) begin
            if (last_t == 7 * P + 40 * 4 + 1) break;
            step();
        end
        chk("reach_row7_col40", last_t, 7 * P + 161);
        #2;
        do_reset();
        #1;
        chk("reset_now", 32'(out_vec()), 32'h2);
        step();
        chk("reset_next_cycle", 32'(out_vec()), 32'h2);
        start_scan();
        chk("restart_addr", {19'd0, rd_en, rd_addr}, 32'h1000);

        // single distinct pixels at column 63 of row pair 31
        do_reset();
        for (int a = 0; a < 4096; a++) fb[a] = 3'b000;
        fb[31 * 64 + 63] = 3'b010;
        fb[63 * 64 + 63] = 3'b001;
        repeat (2) @(negedge clk_in);
        start_scan();
        for (int i = 0; i < FRAME; i++) begin
            if (last_t == 31 * P - 1) break;
            step();
        end
        rises    = 0;
        prev_clk = CLK;
        for (int i = 0; i < P; i++) begin
            step();
            if (CLK && !prev_clk) begin
                rises++;
                if (rises == 63) chk("row31_rise63", 32'(rgb_now()), 32'b000000);
                if (rises == 64) chk("row31_rise64", 32'(rgb_now()), 32'b010001);
            end
            prev_clk = CLK;
        end
        chk("row31_rises", rises, 64);
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
